dram_cmd_sequencer: RTL

//  Downstream consumer of the 16-entry memory-controller request queue. Pops one
//  38-bit request {op[1:0], addr[35:0]} at a time and decodes it into
//  ACT0/ACT1, RD0/RD1 or WR0/WR1, then PRE. Each command is issued on the

---
 rtl/dram_cmd_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_sequencer.sv
// Closed-page DRAM command sequencer: pops one request from the queue head and
// issues ACT0/ACT1, RD*/WR*, PRE on the command bus with tRCD/tRAS/tRTP/tWR/tRP spacing.
module dram_cmd_sequencer #(
    parameter int unsigned T_RCD = 39,
    parameter int unsigned T_RAS = 76,
    parameter int unsigned T_RTP = 18,
    parameter int unsigned T_WRP = 94,
    parameter int unsigned T_RP  = 39
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [37:0] req_data,
    output logic        req_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic        cmd_channel,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [5:0]  cmd_col,
    output logic        err_illegal_op
);

    localparam int unsigned P_RD_I = (T_RAS > T_RCD + T_RTP) ? T_RAS : T_RCD + T_RTP;
    localparam int unsigned P_WR_I = (T_RAS > T_RCD + T_WRP) ? T_RAS : T_RCD + T_WRP;
    localparam logic [8:0]  RCD    = 9'(T_RCD);
    localparam logic [8:0]  P_RD   = 9'(P_RD_I);
    localparam logic [8:0]  P_WR   = 9'(P_WR_I);
    localparam logic [8:0]  RP     = 9'(T_RP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT0,
        S_ACT1,
        S_WAIT_RCD,
        S_CAS0,
        S_CAS1,
        S_WAIT_PRE,
        S_PRE,
        S_WAIT_RP
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT0,
        CMD_ACT1,
        CMD_RD0,
        CMD_RD1,
        CMD_WR0,
        CMD_WR1,
        CMD_PRE
    } cmd_t;

    state_t      state_q;
    cmd_t        cmd_code_q;
    logic [37:0] req_q;
    logic [7:0]  cnt_q;
    logic        cnt_hi_q;
    logic        req_ready_q;
    logic        cmd_valid_q;
    logic        cmd_channel_q;
    logic [2:0]  cmd_bg_q;
    logic [1:0]  cmd_bank_q;
    logic [15:0] cmd_row_q;
    logic [5:0]  cmd_col_q;
    logic        err_q;

    logic [8:0]  cnt_d;
    logic [8:0]  pre_at;
    logic [35:0] addr_src;
    logic        is_wr;
    logic        accept;
    logic        unused_bits;

    // cnt_hi_q extends the 8-bit cycle counter so long PRE delays never wrap.
    always_comb begin
        cnt_d    = {cnt_hi_q, cnt_q} + 9'd1;
        is_wr    = (req_q[37:36] == 2'b01);
        pre_at   = is_wr ? P_WR : P_RD;
        accept   = req_valid && req_ready_q;
        addr_src = (state_q == S_IDLE) ? req_data[35:0] : req_q[35:0];
    end

    assign unused_bits = ^{addr_src[35:34], addr_src[5:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cmd_code_q    <= CMD_NOP;
            req_q         <= '0;
            cnt_q         <= '0;
            cnt_hi_q      <= 1'b0;
            req_ready_q   <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= 1'b0;
            cmd_bg_q      <= '0;
            cmd_bank_q    <= '0;
            cmd_row_q     <= '0;
            cmd_col_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= CMD_NOP;
            cmd_channel_q <= 1'b0;
            cmd_bg_q      <= '0;
            cmd_bank_q    <= '0;
            cmd_row_q     <= '0;
            cmd_col_q     <= '0;
            err_q         <= 1'b0;
            cnt_q         <= cnt_d[7:0];
            cnt_hi_q      <= cnt_hi_q | cnt_d[8];

            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        if (req_data[37:36] == 2'b11) begin
                            err_q <= 1'b1;
                        end else begin
                            // ACT0 fields come from req_data here, which is the value being latched.
                            req_q         <= req_data;
                            req_ready_q   <= 1'b0;
                            state_q       <= S_ACT0;
                            cnt_q         <= '0;
                            cnt_hi_q      <= 1'b0;
                            cmd_valid_q   <= 1'b1;
                            cmd_code_q    <= CMD_ACT0;
                            cmd_channel_q <= addr_src[6];
                            cmd_bg_q      <= addr_src[9:7];
                            cmd_bank_q    <= addr_src[11:10];
                            cmd_row_q     <= addr_src[33:18];
                        end
                    end
                end

                S_ACT0: begin
                    state_q       <= S_ACT1;
                    cmd_valid_q   <= 1'b1;
                    cmd_code_q    <= CMD_ACT1;
                    cmd_channel_q <= addr_src[6];
                    cmd_bg_q      <= addr_src[9:7];
                    cmd_bank_q    <= addr_src[11:10];
                    cmd_row_q     <= addr_src[33:18];
                end

                S_ACT1, S_WAIT_RCD: begin
                    if (cnt_d == RCD) begin
                        state_q       <= S_CAS0;
                        cmd_valid_q   <= 1'b1;
                        cmd_code_q    <= is_wr ? CMD_WR0 : CMD_RD0;
                        cmd_channel_q <= addr_src[6];
                        cmd_bg_q      <= addr_src[9:7];
                        cmd_bank_q    <= addr_src[11:10];
                        cmd_col_q     <= addr_src[17:12];
                    end else begin
                        state_q <= S_WAIT_RCD;
                    end
                end

                S_CAS0: begin
                    state_q       <= S_CAS1;
                    cmd_valid_q   <= 1'b1;
                    cmd_code_q    <= is_wr ? CMD_WR1 : CMD_RD1;
                    cmd_channel_q <= addr_src[6];
                    cmd_bg_q      <= addr_src[9:7];
                    cmd_bank_q    <= addr_src[11:10];
                    cmd_col_q     <= addr_src[17:12];
                end

                S_CAS1, S_WAIT_PRE: begin
                    if (cnt_d == pre_at) begin
                        state_q       <= S_PRE;
                        cnt_q         <= '0;
                        cnt_hi_q      <= 1'b0;
                        cmd_valid_q   <= 1'b1;
                        cmd_code_q    <= CMD_PRE;
                        cmd_channel_q <= addr_src[6];
                        cmd_bg_q      <= addr_src[9:7];
                        cmd_bank_q    <= addr_src[11:10];
                    end else begin
                        state_q <= S_WAIT_PRE;
                    end
                end

                S_PRE, S_WAIT_RP: begin
                    if (cnt_d == RP) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT_RP;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_code       = cmd_code_q;
    assign cmd_channel    = cmd_channel_q;
    assign cmd_bg         = cmd_bg_q;
    assign cmd_bank       = cmd_bank_q;
    assign cmd_row        = cmd_row_q;
    assign cmd_col        = cmd_col_q;
    assign err_illegal_op = err_q;

endmodule
